// File: rtl/scan_bist_pkg.sv
// Shared types and defaults for the scan-chain BIST controller and its latency counter.
// Pure declarations: no logic, no latency, no flow control.
package scan_bist_pkg;

  localparam int CHAIN_LEN_DEF  = 80;
  localparam int NUM_PASSES_DEF = 4;

  typedef enum logic [2:0] {IDLE, FLUSH, INJECT, WAIT, DONE} state_t;
  typedef enum logic [1:0] {NONE, EARLY, LATE, TIMEOUT} err_kind_t;

endpackage

// File: rtl/scan_bist_lat_cnt.sv
// Loadable saturating up-counter with compares at LEN and 2*LEN; load wins over count.
// One-cycle register latency; no backpressure, the counter always accepts load/enable.
module scan_bist_lat_cnt #(
  parameter int LEN = 80,
  parameter int W   = $clog2(2*LEN+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         eq_len_o,
  output logic         eq_2len_o
);
  import scan_bist_pkg::*;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign eq_len_o  = (cnt_q == W'(LEN));
  assign eq_2len_o = (cnt_q == W'(2*LEN));

endmodule

// File: rtl/scan_chain_bist_ctrl.sv
// Scan-chain BIST sequencer: flushes, injects one-cycle markers, checks arrival latency per pass.
// All outputs registered (one cycle after the deciding input); start ignored while busy, abort ends the run.
module scan_chain_bist_ctrl
  import scan_bist_pkg::*;
#(
  parameter int  CHAIN_LEN  = CHAIN_LEN_DEF,
  parameter int  NUM_PASSES = NUM_PASSES_DEF,
  parameter int  ERR_W      = 8,
  localparam int LAT_W      = $clog2(2*CHAIN_LEN+1),
  localparam int PIDX_W     = $clog2(NUM_PASSES+1)
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              sc_tail,
  output logic              sc_head,
  output logic              test_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [LAT_W-1:0]  last_latency,
  output logic [PIDX_W-1:0] pass_idx
);

  state_t              state_q, state_d;
  err_kind_t           err_kind;
  logic                term;
  logic                sc_head_q, test_en_q, busy_q, done_q, pass_q, pass_d, busy_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [PIDX_W-1:0]   pidx_q, pidx_d;
  logic [LAT_W-1:0]    cnt, cnt_load_val;
  logic                cnt_load, eq_len, eq_2len;

  // FLUSH counts 1..CHAIN_LEN so it lasts exactly CHAIN_LEN cycles; INJECT starts at 0 so the
  // count in WAIT equals cycles elapsed since sc_head was high.
  assign cnt_load     = (state_d != state_q) && ((state_d == FLUSH) || (state_d == INJECT));
  assign cnt_load_val = (state_d == FLUSH) ? LAT_W'(1) : '0;

  scan_bist_lat_cnt #(.LEN(CHAIN_LEN), .W(LAT_W)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (Reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (state_q != IDLE),
    .cnt_o      (cnt),
    .eq_len_o   (eq_len),
    .eq_2len_o  (eq_2len)
  );

  always_comb begin
    state_d   = state_q;
    err_kind  = NONE;
    term      = 1'b0;
    err_cnt_d = err_cnt_q;
    lat_d     = lat_q;
    pidx_d    = pidx_q;
    pass_d    = pass_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = FLUSH;
          err_cnt_d = '0;
          pidx_d    = '0;
          pass_d    = 1'b0;
        end
      end
      FLUSH: begin
        if (abort)       state_d = DONE;
        else if (eq_len) state_d = INJECT;
      end
      INJECT: begin
        state_d = abort ? DONE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_d = DONE;
        end else begin
          if (sc_tail) begin
            term = 1'b1;
            if (cnt < LAT_W'(CHAIN_LEN))       err_kind = EARLY;
            else if (cnt != LAT_W'(CHAIN_LEN)) err_kind = LATE;
          end else if (eq_2len) begin
            term     = 1'b1;
            err_kind = TIMEOUT;
          end
          if (term) begin
            pidx_d = pidx_q + PIDX_W'(1);
            lat_d  = (err_kind == TIMEOUT) ? '1 : cnt;
            if ((err_kind != NONE) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (pidx_d == PIDX_W'(NUM_PASSES)) state_d = DONE;
            else if (err_kind == NONE)         state_d = INJECT;
            else                               state_d = FLUSH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != DONE) && (state_d == DONE)) pass_d = !abort && (err_cnt_d == '0);
  end

  assign busy_d = (state_d == FLUSH) || (state_d == INJECT) || (state_d == WAIT);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      sc_head_q <= 1'b0;
      test_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      lat_q     <= '0;
      pidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      sc_head_q <= (state_d == INJECT);
      test_en_q <= busy_d;
      busy_q    <= busy_d;
      done_q    <= (state_d == DONE);
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      lat_q     <= lat_d;
      pidx_q    <= pidx_d;
    end
  end

  assign sc_head      = sc_head_q;
  assign test_en      = test_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_cnt_q;
  assign last_latency = lat_q;
  assign pass_idx     = pidx_q;

endmodule

// File: tb/tb_scan_chain_bist_ctrl.sv
// Bench for scan_chain_bist_ctrl: behavioural scan chain of programmable length plus a
// scoreboard of expected per-pass latencies and end-of-run results.
module tb_scan_chain_bist_ctrl;
  localparam int LEN = 80;
  localparam int NP  = 4;
  localparam int LW  = 8;
  localparam int EW  = 8;
  localparam int PW  = 3;

  logic          clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sc_tail;
  logic          sc_head, test_en, busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [LW-1:0] last_latency;
  logic [PW-1:0] pass_idx;

  always #5 clk = ~clk;

  scan_chain_bist_ctrl #(.CHAIN_LEN(LEN), .NUM_PASSES(NP), .ERR_W(EW)) dut (
    .clk          (clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .abort        (abort),
    .sc_tail      (sc_tail),
    .sc_head      (sc_head),
    .test_en      (test_en),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .last_latency (last_latency),
    .pass_idx     (pass_idx)
  );

  // Fabric model: chain_len flops from sc_head to sc_tail, or a stuck-at-0 tail.
  logic [127:0] chain = '0;
  int           chain_len = LEN;
  bit           tie0 = 1'b0;
  always @(posedge clk) chain <= {chain[126:0], sc_head};
  assign sc_tail = tie0 ? 1'b0 : chain[chain_len-1];

  typedef struct {
    bit is_done;
    int lat;
    int pidx;
    int ok;
    int err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   prev_pidx = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Reset_n && (int'(pass_idx) != prev_pidx) && (pass_idx != '0)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pass", int'(pass_idx), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_kind_pass", 0, int'(mon_e.is_done));
        chk("pass_latency", int'(last_latency), mon_e.lat);
        chk("pass_idx_step", int'(pass_idx), mon_e.pidx);
      end
    end
    prev_pidx = int'(pass_idx);
    if (done) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", int'(done), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_kind_done", 1, int'(mon_e.is_done));
        chk("done_pass", int'(pass), mon_e.ok);
        chk("done_err_cnt", int'(err_cnt), mon_e.err);
        chk("done_latency", int'(last_latency), mon_e.lat);
        chk("done_pass_idx", int'(pass_idx), mon_e.pidx);
        chk("done_busy", int'(busy), 0);
        chk("done_test_en", int'(test_en), 0);
      end
    end
  end

  task automatic push_run(input int lat, input int passes, input int ok, input int err,
                          input int done_lat);
    for (int i = 1; i <= passes; i++) sb.push_back('{1'b0, lat, i, 0, 0});
    sb.push_back('{1'b1, done_lat, passes, ok, err});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_chain(input int len, input bit tie, input int lat, input int ok,
                           input int err);
    int n;
    chain_len = len;
    tie0      = tie;
    push_run(lat, NP, ok, err, lat);
    @(negedge clk);
    pulse_start();
    chk("start_busy", int'(busy), 1);
    chk("start_test_en", int'(test_en), 1);
    n = 0;
    while (!sc_head && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("flush_len", n, LEN);
    n = 0;
    while (!done && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk("done_seen", int'(done), 1);
    @(negedge clk);
    chk("done_single_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("pass_hold", int'(pass), ok);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n;
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sc_head", int'(sc_head), 0);
    chk("rst_test_en", int'(test_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_latency", int'(last_latency), 0);
    chk("rst_pass_idx", int'(pass_idx), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_chain(LEN,     1'b0, LEN,     1, 0);
    run_chain(LEN - 1, 1'b0, LEN - 1, 0, NP);
    run_chain(LEN + 1, 1'b0, LEN + 1, 0, NP);
    run_chain(LEN,     1'b1, 255,     0, NP);

    // Abort in the WAIT of pass 2, then a start during the done cycle.
    chain_len = LEN;
    tie0      = 1'b0;
    push_run(LEN, 1, 0, 0, LEN);
    pulse_start();
    n = 0;
    while (pass_idx != PW'(1) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (!sc_head && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("abort_reached_inject2", int'(sc_head), 1);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_sc_head", int'(sc_head), 0);
    chk("abort_test_en", int'(test_en), 0);
    chk("abort_done", int'(done), 1);
    chk("abort_pass", int'(pass), 0);
    chk("abort_pass_idx", int'(pass_idx), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_start_ignored", int'(busy), 0);
    repeat (5) @(negedge clk);
    chk("abort_still_idle", int'(busy), 0);
    chk("abort_still_no_test", int'(test_en), 0);
    chk("abort_sb_drained", sb.size(), 0);

    // Reset mid-FLUSH: outputs clear asynchronously and no done appears.
    pulse_start();
    repeat (20) @(negedge clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_test_en", int'(test_en), 0);
    chk("midrst_latency", int'(last_latency), 0);
    chk("midrst_pass_idx", int'(pass_idx), 0);
    chk("midrst_done", int'(done), 0);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", int'(done), 0);
    run_chain(LEN, 1'b0, LEN, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
